// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types, reset defaults and helpers for the programmable
// serial pattern detector (seq_detect_ctrl / seq_det_core).
package seq_det_pkg;

    // Control FSM states; ST_DONE is only reachable when SEQ_DET_LIMIT_EN is defined
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Overlap mode after reset: overlapping detection
    localparam logic DEF_OVERLAP = 1'b1;

    // Pattern length after reset is the full pattern width
    function automatic int default_len(input int max_len);
        return max_len;
    endfunction

    // A requested length of 0 means 1; anything above the maximum is clamped
    function automatic int clamp_len(input int raw, input int max_len);
        int res;
        res = raw;
        if (raw < 1) begin
            res = 1;
        end else if (raw > max_len) begin
            res = max_len;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_det_core.sv
// seq_det_core: history shift register, fill counter and length-masked
// compare. hit is combinational and only asserted on a shift cycle.
module seq_det_core
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             hit
);

    logic [PAT_W-1:0] history;
    logic [LEN_W-1:0] fill;
    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic             enough;

    // The incoming bit is the newest (bit 0) of the comparison window
    assign window = {history[PAT_W-2:0], din};

    // A match needs len valid bits including the current one, so reset zeros
    // in the history can never complete a pattern
    assign enough = ((LEN_W + 1)'(fill) + (LEN_W + 1)'(1)) >= (LEN_W + 1)'(len);

    // Only the low len bits of the window take part in the compare
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    // Match decision for the current shift cycle
    always_comb begin
        hit = shift_en && enough && (((window ^ pattern) & mask) == '0);
    end

    // History and fill tracking; non-overlap mode restarts fill after a match
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            history <= '0;
            fill    <= '0;
        end else if (clr) begin
            history <= '0;
            fill    <= '0;
        end else if (shift_en) begin
            history <= window;
            if (hit && !overlap) begin
                fill <= '0;
            end else if (fill < len) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run-time programmable serial pattern detector with an
// IDLE/RUN(/DONE) control FSM, saturating match counter and registered
// outputs. Optional feature macro: SEQ_DET_LIMIT_EN adds cfg_limit, done and
// the DONE state (auto-stop after a programmed number of matches).
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       din,
    input  logic                       din_valid,
    input  logic                       cfg_we,
    input  logic [PAT_W-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
    input  logic                       cfg_overlap,
`ifdef SEQ_DET_LIMIT_EN
    input  logic [CNT_W-1:0]           cfg_limit,
    output logic                       done,
`endif
    input  logic                       start,
    input  logic                       stop,
    output logic                       busy,
    output logic                       match,
    output logic [CNT_W-1:0]           match_count,
    output logic                       count_sat
);

    localparam int LEN_W = $clog2(PAT_W + 1);

    state_t           state;
    logic [PAT_W-1:0] pattern_reg;
    logic [LEN_W-1:0] len_reg;
    logic             overlap_reg;
    logic             shift_en;
    logic             clr;
    logic             hit;
    logic [CNT_W-1:0] count_next;
`ifdef SEQ_DET_LIMIT_EN
    logic [CNT_W-1:0] limit_reg;
    logic             limit_hit;
`endif

    // stop has priority over start; start clears the history, and the din
    // present on a start or stop edge is never evaluated
    assign clr      = start && !stop;
    assign shift_en = (state == ST_RUN) && din_valid && !start && !stop;

    // Saturating increment of the match counter
    assign count_next = (match_count == '1) ? match_count : match_count + 1'b1;

`ifdef SEQ_DET_LIMIT_EN
    // Limit 0 disables auto-stop
    assign limit_hit = (limit_reg != '0) && (count_next == limit_reg);
`endif

    // Configuration registers, writable only while not running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_reg <= '0;
            len_reg     <= LEN_W'(default_len(PAT_W));
            overlap_reg <= DEF_OVERLAP;
`ifdef SEQ_DET_LIMIT_EN
            limit_reg   <= '0;
`endif
        end else if (cfg_we && (state != ST_RUN)) begin
            pattern_reg <= cfg_pattern;
            len_reg     <= LEN_W'(clamp_len(int'(cfg_len), PAT_W));
            overlap_reg <= cfg_overlap;
`ifdef SEQ_DET_LIMIT_EN
            limit_reg   <= cfg_limit;
`endif
        end
    end

    seq_det_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .shift_en (shift_en),
        .clr      (clr),
        .din      (din),
        .pattern  (pattern_reg),
        .len      (len_reg),
        .overlap  (overlap_reg),
        .hit      (hit)
    );

    // Control FSM with registered busy/match/count/done outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            match       <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
`ifdef SEQ_DET_LIMIT_EN
            done        <= 1'b0;
`endif
        end else begin
            match <= 1'b0;
            if (stop) begin
                // Count and saturation flag stay readable until the next start
                state <= ST_IDLE;
                busy  <= 1'b0;
`ifdef SEQ_DET_LIMIT_EN
                done  <= 1'b0;
`endif
            end else if (start) begin
                // Arm or re-arm from any state
                state       <= ST_RUN;
                busy        <= 1'b1;
                match_count <= '0;
                count_sat   <= 1'b0;
`ifdef SEQ_DET_LIMIT_EN
                done        <= 1'b0;
`endif
            end else if (hit) begin
                match       <= 1'b1;
                match_count <= count_next;
                if (count_next == '1) begin
                    count_sat <= 1'b1;
                end
`ifdef SEQ_DET_LIMIT_EN
                if (limit_hit) begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: the stimulus process pushes the edge
// number and count of each expected match; a monitor pops on every match pulse.
module tb_seq_detect_ctrl;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             cfg_we = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;
`ifdef SEQ_DET_LIMIT_EN
    logic [CNT_W-1:0] cfg_limit = '0;
    logic             done;
`endif

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    seq_detect_ctrl #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .din_valid   (din_valid),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
`ifdef SEQ_DET_LIMIT_EN
        .cfg_limit   (cfg_limit),
        .done        (done),
`endif
        .start       (start),
        .stop        (stop),
        .busy        (busy),
        .match       (match),
        .match_count (match_count),
        .count_sat   (count_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every match pulse must be the next expected one, on its edge
    always @(negedge clk) begin
        if (match) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_match edge=%0d count=%0d required no match", cyc, match_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || int'(match_count) != e.cnt) begin
                    errors++;
                    $display("FAIL match edge=%0d count=%0d required edge=%0d count=%0d",
                             cyc, match_count, e.cyc, e.cnt);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [PAT_W-1:0] pat, input int len, input logic ov, input int lim);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ov;
`ifdef SEQ_DET_LIMIT_EN
        cfg_limit   = CNT_W'(lim);
`else
        if (lim != 0) $display("note: limit %0d ignored in this build", lim);
`endif
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic arm(input string name);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_busy"}, int'(busy), 1);
        check({name, "_count_clr"}, int'(match_count), 0);
    endtask

    task automatic disarm(input string name);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check({name, "_busy_off"}, int'(busy), 0);
    endtask

    // Drive one valid bit; if a match is expected, queue it for the next edge
    task automatic send(input logic b, input bit exp_m, input int exp_c);
        din       = b;
        din_valid = 1'b1;
        if (exp_m) begin
            exp_t e;
            e.cyc = cyc + 1;
            e.cnt = exp_c;
            exp_q.push_back(e);
        end
        tick();
        din_valid = 1'b0;
        din       = 1'b0;
    endtask

    task automatic gap();
        din       = 1'b1;
        din_valid = 1'b0;
        tick();
        din = 1'b0;
    endtask

    task automatic drain(input string name);
        tick();
        tick();
        check({name, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_match", int'(match), 0);
        check("rst_count", int'(match_count), 0);
        check("rst_sat", int'(count_sat), 0);
`ifdef SEQ_DET_LIMIT_EN
        check("rst_done", int'(done), 0);
`endif
        tick();
        reset_n = 1'b1;
        tick();

        // Overlapping 1001
        cfg(8'b1001, 4, 1'b1, 0);
        arm("ov");
        send(1, 0, 0); send(0, 0, 0); send(0, 0, 0); send(1, 1, 1);
        send(0, 0, 0); send(0, 0, 0); send(1, 1, 2);
        drain("ov");
        check("ov_count", int'(match_count), 2);
        disarm("ov");
        check("ov_count_held", int'(match_count), 2);

        // Non-overlapping 1001
        cfg(8'b1001, 4, 1'b0, 0);
        arm("nov");
        send(1, 0, 0); send(0, 0, 0); send(0, 0, 0); send(1, 1, 1);
        send(0, 0, 0); send(0, 0, 0); send(1, 0, 0);
        drain("nov");
        check("nov_count", int'(match_count), 1);
        disarm("nov");

        // Valid gaps are transparent
        cfg(8'b1001, 4, 1'b1, 0);
        arm("gap");
        send(1, 0, 0); gap(); send(0, 0, 0); send(0, 0, 0); gap(); gap();
        send(1, 1, 1); send(0, 0, 0); gap(); send(0, 0, 0); send(1, 1, 2);
        drain("gap");
        check("gap_count", int'(match_count), 2);
        disarm("gap");

        // Pattern 000 straight after start: first match only on the 3rd zero
        cfg(8'b000, 3, 1'b0, 0);
        arm("zero");
        send(0, 0, 0); send(0, 0, 0); send(0, 1, 1);
        drain("zero");
        disarm("zero");

        // Length 0 is loaded as 1
        cfg(8'h01, 0, 1'b1, 0);
        arm("len0");
        send(0, 0, 0); send(1, 1, 1); send(0, 0, 0);
        drain("len0");
        disarm("len0");

        // Config write while running is ignored
        cfg(8'b11, 2, 1'b1, 0);
        arm("lock");
        cfg(8'b00, 2, 1'b1, 0);
        send(0, 0, 0); send(0, 0, 0); send(1, 0, 0); send(1, 1, 1);
        drain("lock");

        // start together with stop while running: stop wins
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", int'(busy), 0);
        check("startstop_count", int'(match_count), 1);

        // Saturation with a 2-bit counter
        arm("sat");
        send(1, 0, 0); send(1, 1, 1); send(1, 1, 2);
        check("sat_early", int'(count_sat), 0);
        send(1, 1, 3); send(1, 1, 3);
        drain("sat");
        check("sat_count", int'(match_count), 3);
        check("sat_flag", int'(count_sat), 1);
        disarm("sat");
        check("sat_sticky", int'(count_sat), 1);
        arm("sat_rearm");
        check("sat_cleared", int'(count_sat), 0);
        disarm("sat_rearm");

`ifdef SEQ_DET_LIMIT_EN
        // Auto-stop after 3 matches
        cfg(8'b11, 2, 1'b1, 3);
        arm("lim");
        send(1, 0, 0); send(1, 1, 1); send(1, 1, 2); send(1, 1, 3);
        check("lim_done", int'(done), 1);
        check("lim_busy", int'(busy), 0);
        send(1, 0, 0); send(1, 0, 0);
        drain("lim");
        check("lim_count", int'(match_count), 3);
        disarm("lim");
        check("lim_done_clr", int'(done), 0);
        cfg(8'b11, 2, 1'b1, 0);
`endif

        // Reset after 3 of 4 bits, then only the 4th bit after restart
        cfg(8'b1001, 4, 1'b1, 0);
        arm("rst");
        send(1, 0, 0); send(0, 0, 0); send(0, 0, 0);
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_match", int'(match), 0);
        check("rst_mid_count", int'(match_count), 0);
        tick();
        reset_n = 1'b1;
        tick();
        cfg(8'b1001, 4, 1'b1, 0);
        arm("rst2");
        send(1, 0, 0);
        drain("rst2");
        check("rst2_count", int'(match_count), 0);
        disarm("rst2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
